regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two write-back requesters: the ALU path and the load/memory path.
- Round-robin arbitration with valid/ready handshakes; registered write-port outputs.
- Holds a pending-load scoreboard so that decode can detect RAW hazards.
- Orders writes so that a younger ALU write never overtakes an outstanding load to the same register (WAW).

Parameters:
XLEN, 32, data width of the register file write port
AW, 5, register address width (2**AW registers; register 0 hardwired zero)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
alu_valid  input  1  ALU write-back request
alu_ready  output  1  ALU request accepted this cycle
alu_rd  input  AW  ALU destination register
alu_data  input  XLEN  ALU result
mem_valid  input  1  load write-back request
mem_ready  output  1  load request accepted this cycle
mem_rd  input  AW  load destination register
mem_data  input  XLEN  load result
issue_valid  input  1  a load is being issued; mark its rd pending
issue_ready  output  1  load issue accepted
issue_rd  input  AW  destination of the issued load
rs1  input  AW  decode source 1
rs2  input  AW  decode source 2
rs1_busy  output  1  rs1 has an outstanding load
rs2_busy  output  1  rs2 has an outstanding load
pending  output  2**AW  scoreboard bit vector
rf_write_enable  output  1  register file write enable
rf_write_reg  output  AW  register file write address
rf_write_data  output  XLEN  register file write data

Behaviour:
- Reset values: rf_write_enable=0, rf_write_reg=0, rf_write_data=0, pending=0. The round-robin pointer is set to "last grant = mem", so the ALU wins the first contention. Reset asserted mid-operation discards all in-flight state immediately.
- Handshake: a transfer occurs when valid && ready on the same rising edge. A requester holds valid, rd and data stable until ready. The ready signals are combinational from the current inputs and state.
- Eligibility:
  - mem is eligible when mem_valid=1.
  - ALU is eligible when alu_valid=1 and pending[alu_rd]=0 (WAW stall). rd=0 is always eligible.
- Arbitration:
  - Only one eligible requester: it is granted.
  - Both eligible: grant the one NOT granted last.
  - The pointer updates only on an actual grant.
  - At most one of alu_ready and mem_ready is high in any cycle.
- Write port: on the edge of a granted transfer with rd!=0, the next cycle has rf_write_enable=1, rf_write_reg=rd and rf_write_data=data (1-cycle latency). In every other cycle rf_write_enable=0 and reg/data hold their previous values.
- rd=0: the request is accepted normally (ready asserted, pointer updated), but rf_write_enable stays 0. The scoreboard never sets bit 0.
- Scoreboard set: issue_ready = !pending[issue_rd] || (mem transfer this cycle with mem_rd==issue_rd). On issue transfer with issue_rd!=0, pending[issue_rd] is 1 from the next cycle.
- Scoreboard clear: on mem transfer, pending[mem_rd] is cleared next cycle.
- Same-cycle clear and set of the same rd: set wins, so the bit stays 1.
- A mem response to a register that is not pending is still written; the bit stays 0.
- rsN_busy = pending[rsN], combinational, with pending[0] always 0. No bypass: a register cleared this cycle reads busy until the next edge, because the register file write also lands one cycle later.
- No deadlock: mem is never blocked by the scoreboard, so an ALU WAW stall always resolves once the load returns.

Test Plan:
- ALU-only: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle rf_write_enable=1, reg=5, data=0xDEADBEEF; cycle after, enable=0.
- Contention: both valid for 4 cycles, alu rd=1, mem rd=2 -> grants ALU, mem, ALU, mem (first after reset = ALU); writes to reg 1, 2, 1, 2 each one cycle later; the two ready signals are never both high.
- WAW stall:
  - Cycle 0: issue load rd=7 -> pending[7]=1.
  - Cycle 2: alu_valid rd=7 -> alu_ready=0 while pending.
  - Cycle 4: mem_valid rd=7 data=0x11 -> mem accepted.
  - Cycle 5: write of 0x11 to reg 7, pending[7]=0, ALU accepted.
  - Cycle 6: ALU write to reg 7 lands after the load value.
- x0 and busy: issue load rd=0 -> pending stays 0, rs1=0 gives busy=0. ALU write rd=0 -> alu_ready=1, rf_write_enable stays 0. Issue rd=3 with rs2=3 -> rs2_busy=1 from the next cycle.
- Re-issue same rd: pending[9]=1 and issue rd=9 with no mem return -> issue_ready=0. Same cycle as mem transfer rd=9 -> issue_ready=1 and pending[9] stays 1.
- Reset mid-op: pending[4]=1, ALU stalled on rd=4, assert reset asynchronously between edges -> pending=0 and rf_write_enable=0 immediately. After release, ALU rd=4 is granted on the first cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load write-back, and tracks loads still in flight.
// Latency: the write port is registered, so it fires one cycle after the grant. Scoreboard bits change one cycle after the issue or the return.
// Backpressure: alu_ready/mem_ready are combinational round-robin grants. An ALU write stalls while its rd has a load in flight. A load return is never stalled.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [AW-1:0]        alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [AW-1:0]        mem_rd,
    input  logic [XLEN-1:0]      mem_data,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [AW-1:0]        issue_rd,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [(2**AW)-1:0]   pending,
    output logic                 rf_write_enable,
    output logic [AW-1:0]        rf_write_reg,
    output logic [XLEN-1:0]      rf_write_data
);

    localparam int NREG = 2**AW;

    // 1 when the most recent grant went to the load path.
    logic            last_mem;
    logic            alu_elig;
    logic            mem_elig;
    logic            grant_alu;
    logic            grant_mem;
    logic            issue_xfer;
    logic [NREG-1:0] pending_nxt;

    // Eligibility and round-robin grant. The ALU waits on a pending rd so it cannot overtake the load (WAW).
    always_comb begin
        alu_elig    = alu_valid && ((alu_rd == '0) || !pending[alu_rd]);
        mem_elig    = mem_valid;
        grant_alu   = alu_elig && (!mem_elig || last_mem);
        grant_mem   = mem_elig && (!alu_elig || !last_mem);
        alu_ready   = grant_alu;
        mem_ready   = grant_mem;
        issue_ready = !pending[issue_rd] || (grant_mem && (mem_rd == issue_rd));
        issue_xfer  = issue_valid && issue_ready;
        rs1_busy    = pending[rs1];
        rs2_busy    = pending[rs2];
    end

    // Next scoreboard value. The set is applied after the clear, so a same-cycle re-issue keeps the bit.
    always_comb begin
        pending_nxt = pending;
        if (grant_mem) begin
            pending_nxt[mem_rd] = 1'b0;
        end
        if (issue_xfer && (issue_rd != '0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Registered write port, scoreboard and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending         <= '0;
            last_mem        <= 1'b1;
            rf_write_enable <= 1'b0;
            rf_write_reg    <= '0;
            rf_write_data   <= '0;
        end else begin
            pending <= pending_nxt;
            if (grant_alu) begin
                last_mem <= 1'b0;
            end else if (grant_mem) begin
                last_mem <= 1'b1;
            end
            if (grant_alu && (alu_rd != '0)) begin
                rf_write_enable <= 1'b1;
                rf_write_reg    <= alu_rd;
                rf_write_data   <= alu_data;
            end else if (grant_mem && (mem_rd != '0)) begin
                rf_write_enable <= 1'b1;
                rf_write_reg    <= mem_rd;
                rf_write_data   <= mem_data;
            end else begin
                rf_write_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a behavioural model.
// Inputs change 1 ns after a rising edge. Combinational outputs are read 1 ns later. Registered outputs are read 1 ns after the edge.
// Requesters hold their request until it is accepted.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd, rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic [31:0] pending;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    bit [31:0]   m_pend;
    int          m_last;          // 0 = ALU, 1 = mem
    int          m_win;           // -1 none, 0 ALU, 1 mem
    bit          m_alu_rdy, m_mem_rdy, m_iss_rdy;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .pending(pending),
        .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0; m_last = 1; m_win = -1;
        m_alu_rdy = 0; m_mem_rdy = 0; m_iss_rdy = 0;
        m_we = 1'b0; m_reg = '0; m_data = '0;
    endtask

    // Decide who wins this cycle from the current requests and the model's scoreboard.
    task automatic model_eval();
        bit a_ok, w_ok;
        a_ok = alu_valid && (alu_rd == 0 || !m_pend[alu_rd]);
        w_ok = mem_valid;
        if (a_ok && w_ok) m_win = (m_last == 1) ? 0 : 1;
        else if (a_ok)    m_win = 0;
        else if (w_ok)    m_win = 1;
        else              m_win = -1;
        m_alu_rdy = (m_win == 0);
        m_mem_rdy = (m_win == 1);
        m_iss_rdy = !m_pend[issue_rd] || (m_win == 1 && mem_rd == issue_rd);
    endtask

    task automatic model_commit();
        m_we = 1'b0;
        if (m_win == 0) begin
            m_last = 0;
            if (alu_rd != 0) begin m_we = 1'b1; m_reg = alu_rd; m_data = alu_data; end
        end else if (m_win == 1) begin
            m_last = 1;
            if (mem_rd != 0) begin m_we = 1'b1; m_reg = mem_rd; m_data = mem_data; end
            m_pend[mem_rd] = 1'b0;
        end
        if (issue_valid && m_iss_rdy && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic clock();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                          input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                          input logic iv, input logic [4:0] ird);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        issue_valid = iv; issue_rd = ird;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rs1 = '0; rs2 = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", rf_write_enable); end
        total++; if (rf_write_reg !== 5'd0) begin bad++; $display("FAIL reset_reg got=%0d want=0", rf_write_reg); end
        total++; if (rf_write_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", rf_write_data); end
        total++; if (pending !== 32'd0) begin bad++; $display("FAIL reset_pending got=%h want=0", pending); end
    endtask

    task automatic test_alu_only();
        do_reset();
        set_in(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        settle();
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL alu_only_ready got=%b want=1", alu_ready); end
        clock();
        total++; if ({rf_write_enable, rf_write_reg, rf_write_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin bad++; $display("FAIL alu_only_write got=%b/%0d/%h want=1/5/deadbeef", rf_write_enable, rf_write_reg, rf_write_data); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        clock();
        total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL alu_only_idle_we got=%b want=0", rf_write_enable); end
        total++; if (rf_write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_only_hold got=%h want=deadbeef", rf_write_data); end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bit exp_alu;
            exp_alu = (i % 2 == 0);
            set_in(1, 1, 32'hA000 + i, 1, 2, 32'hB000 + i, 0, 0);
            settle();
            total++; if (alu_ready !== exp_alu) begin bad++; $display("FAIL cont_alu_ready[%0d] got=%b want=%b", i, alu_ready, exp_alu); end
            total++; if (mem_ready !== !exp_alu) begin bad++; $display("FAIL cont_mem_ready[%0d] got=%b want=%b", i, mem_ready, !exp_alu); end
            clock();
            total++; if (rf_write_enable !== 1'b1 || rf_write_reg !== (exp_alu ? 5'd1 : 5'd2)
                         || rf_write_data !== (exp_alu ? 32'hA000 + i : 32'hB000 + i))
                begin bad++; $display("FAIL cont_write[%0d] got=%b/%0d/%h want reg %0d", i, rf_write_enable, rf_write_reg, rf_write_data, exp_alu ? 1 : 2); end
        end
    endtask

    task automatic test_waw();
        do_reset();
        rs1 = 5'd7;
        set_in(0, 0, 0, 0, 0, 0, 1, 7);
        settle();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL waw_issue_ready got=%b want=1", issue_ready); end
        clock();
        total++; if (pending[7] !== 1'b1) begin bad++; $display("FAIL waw_pending_set got=%b want=1", pending[7]); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        clock();
        for (int c = 2; c < 4; c++) begin
            set_in(1, 7, 32'h77, 0, 0, 0, 0, 0);
            settle();
            total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL waw_stall[%0d] got=%b want=0", c, alu_ready); end
            clock();
        end
        set_in(1, 7, 32'h77, 1, 7, 32'h11, 0, 0);
        settle();
        total++; if ({mem_ready, alu_ready} !== 2'b10) begin bad++; $display("FAIL waw_mem_grant got=%b want=10", {mem_ready, alu_ready}); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL waw_no_bypass got=%b want=1", rs1_busy); end
        clock();
        total++; if ({rf_write_enable, rf_write_reg, rf_write_data} !== {1'b1, 5'd7, 32'h11})
            begin bad++; $display("FAIL waw_load_write got=%b/%0d/%h want=1/7/11", rf_write_enable, rf_write_reg, rf_write_data); end
        total++; if (pending[7] !== 1'b0) begin bad++; $display("FAIL waw_pending_clr got=%b want=0", pending[7]); end
        set_in(1, 7, 32'h77, 0, 0, 0, 0, 0);
        settle();
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL waw_alu_release got=%b want=1", alu_ready); end
        clock();
        total++; if ({rf_write_enable, rf_write_reg, rf_write_data} !== {1'b1, 5'd7, 32'h77})
            begin bad++; $display("FAIL waw_alu_write got=%b/%0d/%h want=1/7/77", rf_write_enable, rf_write_reg, rf_write_data); end
    endtask

    task automatic test_x0_busy();
        do_reset();
        rs1 = 5'd0;
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL x0_issue_ready got=%b want=1", issue_ready); end
        clock();
        total++; if (pending !== 32'd0) begin bad++; $display("FAIL x0_pending got=%h want=0", pending); end
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL x0_rs1_busy got=%b want=0", rs1_busy); end
        set_in(1, 0, 32'h55, 0, 0, 0, 0, 0);
        settle();
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL x0_alu_ready got=%b want=1", alu_ready); end
        clock();
        total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL x0_no_write got=%b want=0", rf_write_enable); end
        rs2 = 5'd3;
        set_in(0, 0, 0, 0, 0, 0, 1, 3);
        settle();
        total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL busy_before got=%b want=0", rs2_busy); end
        clock();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        total++; if (rs2_busy !== 1'b1) begin bad++; $display("FAIL busy_after got=%b want=1", rs2_busy); end
    endtask

    task automatic test_reissue();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 9);
        settle();
        clock();
        settle();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL reissue_block got=%b want=0", issue_ready); end
        clock();
        set_in(0, 0, 0, 1, 9, 32'h99, 1, 9);
        settle();
        total++; if ({issue_ready, mem_ready} !== 2'b11) begin bad++; $display("FAIL reissue_with_ret got=%b want=11", {issue_ready, mem_ready}); end
        clock();
        total++; if (pending[9] !== 1'b1) begin bad++; $display("FAIL reissue_set_wins got=%b want=1", pending[9]); end
        total++; if ({rf_write_enable, rf_write_reg, rf_write_data} !== {1'b1, 5'd9, 32'h99})
            begin bad++; $display("FAIL reissue_write got=%b/%0d/%h want=1/9/99", rf_write_enable, rf_write_reg, rf_write_data); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 4);
        settle();
        clock();
        set_in(1, 4, 32'h44, 1, 6, 32'h66, 0, 0);
        settle();
        total++; if ({alu_ready, mem_ready} !== 2'b01) begin bad++; $display("FAIL mid_pre_grant got=%b want=01", {alu_ready, mem_ready}); end
        clock();
        set_in(1, 4, 32'h44, 0, 0, 0, 0, 0);
        settle();
        total++; if (rf_write_enable !== 1'b1) begin bad++; $display("FAIL mid_pre_we got=%b want=1", rf_write_enable); end
        #2 reset = 1'b1;
        #1;
        total++; if (pending !== 32'd0) begin bad++; $display("FAIL mid_async_pending got=%h want=0", pending); end
        total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL mid_async_we got=%b want=0", rf_write_enable); end
        model_reset();
        #1 reset = 1'b0;
        set_in(1, 4, 32'h44, 1, 6, 32'h66, 0, 0);
        settle();
        total++; if ({alu_ready, mem_ready} !== 2'b10) begin bad++; $display("FAIL mid_post_grant got=%b want=10", {alu_ready, mem_ready}); end
        clock();
        total++; if ({rf_write_enable, rf_write_reg, rf_write_data} !== {1'b1, 5'd4, 32'h44})
            begin bad++; $display("FAIL mid_post_write got=%b/%0d/%h want=1/4/44", rf_write_enable, rf_write_reg, rf_write_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (!alu_valid || m_alu_rdy) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!mem_valid || m_mem_rdy) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
            end
            if (!issue_valid || m_iss_rdy) begin
                issue_valid = ($urandom_range(0, 2) == 0);
                issue_rd = 5'($urandom_range(0, 7));
            end
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            settle();
            total++; if (alu_ready !== m_alu_rdy) begin bad++; $display("FAIL rnd_alu_ready[%0d] got=%b want=%b", n, alu_ready, m_alu_rdy); end
            total++; if (mem_ready !== m_mem_rdy) begin bad++; $display("FAIL rnd_mem_ready[%0d] got=%b want=%b", n, mem_ready, m_mem_rdy); end
            total++; if (issue_ready !== m_iss_rdy) begin bad++; $display("FAIL rnd_issue_ready[%0d] got=%b want=%b", n, issue_ready, m_iss_rdy); end
            total++; if ({rs1_busy, rs2_busy} !== {m_pend[rs1], m_pend[rs2]})
                begin bad++; $display("FAIL rnd_busy[%0d] got=%b want=%b", n, {rs1_busy, rs2_busy}, {m_pend[rs1], m_pend[rs2]}); end
            total++; if ((alu_ready && mem_ready) !== 1'b0) begin bad++; $display("FAIL rnd_both_ready[%0d] got=1 want=0", n); end
            clock();
            total++; if (rf_write_enable !== m_we) begin bad++; $display("FAIL rnd_we[%0d] got=%b want=%b", n, rf_write_enable, m_we); end
            total++; if ({rf_write_reg, rf_write_data} !== {m_reg, m_data})
                begin bad++; $display("FAIL rnd_port[%0d] got=%0d/%h want=%0d/%h", n, rf_write_reg, rf_write_data, m_reg, m_data); end
            total++; if (pending !== m_pend) begin bad++; $display("FAIL rnd_pending[%0d] got=%h want=%h", n, pending, m_pend); end
        end
    endtask

    initial begin
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rs1 = '0; rs2 = '0;
        reset = 1'b1;
        test_reset();
        test_alu_only();
        test_contention();
        test_waw();
        test_x0_busy();
        test_reissue();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
